// File: rtl/access_enforcer_if.sv
// Request / authenticator / response bundle for access_enforcer.
// slave: the enforcer side. master: the front end, authenticator and consumer side.
interface access_enforcer_if;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_user;
   logic [2:0] req_file;
   logic [1:0] req_op;
   logic [2:0] perm_user;
   logic [2:0] perm_file;
   logic [2:0] perm;
   logic       resp_valid;
   logic       resp_ready;
   logic       resp_grant;
   logic       resp_lock;

   modport slave (
      input  req_valid, req_user, req_file, req_op, perm, resp_ready,
      output req_ready, perm_user, perm_file, resp_valid, resp_grant, resp_lock
   );

   modport master (
      output req_valid, req_user, req_file, req_op, perm, resp_ready,
      input  req_ready, perm_user, perm_file, resp_valid, resp_grant, resp_lock
   );
endinterface

// File: rtl/access_enforcer.sv
// access_enforcer: turns the authenticator's permission vector into handshaked grant/deny
// decisions, with per-user consecutive-failure counting and a timed lockout.
// Optional feature: define ACCESS_AUDIT_EN to add saturating grant_cnt/deny_cnt outputs.
module access_enforcer #(
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ACCESS_AUDIT_EN
   output logic [7:0]        grant_cnt,
   output logic [7:0]        deny_cnt,
`endif
   access_enforcer_if.slave  bus
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StLookup = 2'd1;
   localparam logic [1:0] StCheck  = 2'd2;
   localparam logic [1:0] StResp   = 2'd3;

   logic [1:0] state_q, state_d;
   logic [2:0] perm_user_q, perm_file_q;
   logic [1:0] op_q;
   logic       grant_q, lock_out_q;

   logic [1:0] fail_cnt_q [8];
   logic [1:0] fail_cnt_d [8];
   logic [7:0] timer_q    [8];
   logic [7:0] timer_d    [8];
   logic [7:0] lock_q, lock_d;

   logic       cur_locked, op_ok, dec_grant, dec_fail, fail_hit;
   logic [2:0] fail_inc;

   // Next-state logic of the request FSM
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.req_valid) state_d = StLookup;
         StLookup: state_d = StCheck;
         StCheck:  state_d = StResp;
         StResp:   if (bus.resp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Decision for the registered request; lock state is the pre-edge value
   always_comb begin
      cur_locked = lock_q[perm_user_q];
      unique case (op_q)
         2'b00:   op_ok = bus.perm[0];
         2'b01:   op_ok = bus.perm[1];
         2'b10:   op_ok = bus.perm[2];
         default: op_ok = 1'b0;
      endcase
      dec_grant = !cur_locked && op_ok;
      dec_fail  = !cur_locked && !op_ok;
      fail_inc  = {1'b0, fail_cnt_q[perm_user_q]} + 3'd1;
      fail_hit  = (fail_inc == 3'(MAX_FAIL));
   end

   // Per-user failure counters and lock timers; a lockout load overrides the decrement
   always_comb begin
      lock_d = lock_q;
      for (int u = 0; u < 8; u++) begin
         fail_cnt_d[u] = fail_cnt_q[u];
         timer_d[u]    = timer_q[u];
         if (timer_q[u] != 8'd0) begin
            timer_d[u] = timer_q[u] - 8'd1;
            if (timer_q[u] == 8'd1) lock_d[u] = 1'b0;
         end
         if (state_q == StCheck && perm_user_q == u[2:0]) begin
            if (dec_grant) begin
               fail_cnt_d[u] = 2'd0;
            end else if (dec_fail) begin
               if (fail_hit) begin
                  lock_d[u]     = 1'b1;
                  timer_d[u]    = 8'(LOCK_CYCLES);
                  fail_cnt_d[u] = 2'd0;
               end else begin
                  fail_cnt_d[u] = fail_inc[1:0];
               end
            end
         end
      end
   end

   // State, request capture, decision registers and per-user tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         perm_user_q <= 3'd0;
         perm_file_q <= 3'd0;
         op_q        <= 2'd0;
         grant_q     <= 1'b0;
         lock_out_q  <= 1'b0;
         fail_cnt_q  <= '{default: 2'd0};
         timer_q     <= '{default: 8'd0};
         lock_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         fail_cnt_q <= fail_cnt_d;
         timer_q    <= timer_d;
         lock_q     <= lock_d;
         if (state_q == StIdle && bus.req_valid) begin
            perm_user_q <= bus.req_user;
            perm_file_q <= bus.req_file;
            op_q        <= bus.req_op;
         end
         if (state_q == StCheck) begin
            grant_q    <= dec_grant;
            lock_out_q <= cur_locked;
         end
      end
   end

`ifdef ACCESS_AUDIT_EN
   // Saturating audit counters, bumped on the response handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= 8'd0;
         deny_cnt  <= 8'd0;
      end else if (state_q == StResp && bus.resp_ready) begin
         if (grant_q) begin
            if (grant_cnt != 8'hff) grant_cnt <= grant_cnt + 8'd1;
         end else begin
            if (deny_cnt != 8'hff) deny_cnt <= deny_cnt + 8'd1;
         end
      end
   end
`endif

   assign bus.req_ready  = (state_q == StIdle);
   assign bus.resp_valid = (state_q == StResp);
   assign bus.resp_grant = grant_q;
   assign bus.resp_lock  = lock_out_q;
   assign bus.perm_user  = perm_user_q;
   assign bus.perm_file  = perm_file_q;

endmodule
